// File: rtl/baud_rate_gen_prog_pkg.sv
// -----------------------------------------------------------------------------
// baud_pkg
// Shared defaults for the programmable baud tick generator.
//   NB_DIV      : width of the divisor and the period counter
//   NB_OS       : width of the oversample counter
//   NB_FRAC     : width of the fractional divisor (BAUD_GEN_FRAC_EN builds)
//   OVERSAMPLE  : o_tick periods per o_bit_tick
//   MIN_DIV     : smallest divisor ever applied; smaller loads are clamped
//   DEFAULT_DIV : divisor active after reset (50 MHz, 19200 baud, x16)
// -----------------------------------------------------------------------------
package baud_pkg;

    localparam int NB_DIV      = 16;
    localparam int NB_OS       = 4;
    localparam int NB_FRAC     = 4;
    localparam int OVERSAMPLE  = 16;
    localparam int MIN_DIV     = 2;
    localparam int DEFAULT_DIV = 163;

endpackage : baud_pkg

// File: rtl/baud_rate_gen_prog_if.sv
// -----------------------------------------------------------------------------
// baud_rate_gen_prog_if
// Configuration and tick bundle between the config register block (master)
// and the baud generator (slave).
//   i_enable     : run when high; low clears counters and suppresses ticks
//   i_div        : new divisor value
//   i_div_load   : one-cycle strobe capturing i_div
//   i_frac       : fractional divisor, only when BAUD_GEN_FRAC_EN is defined
//   o_div_ack    : one-cycle pulse when a loaded divisor becomes active
//   o_div_active : divisor currently applied
//   o_tick       : oversample tick, one cycle wide
//   o_bit_tick   : bit tick, one cycle wide, coincident with an o_tick
// Optional feature macro: BAUD_GEN_FRAC_EN
// -----------------------------------------------------------------------------
interface baud_rate_gen_prog_if #(
    parameter int NB_DIV  = baud_pkg::NB_DIV
`ifdef BAUD_GEN_FRAC_EN
    ,
    parameter int NB_FRAC = baud_pkg::NB_FRAC
`endif
);

    logic              i_enable;
    logic [NB_DIV-1:0] i_div;
    logic              i_div_load;
`ifdef BAUD_GEN_FRAC_EN
    logic [NB_FRAC-1:0] i_frac;
`endif
    logic              o_div_ack;
    logic [NB_DIV-1:0] o_div_active;
    logic              o_tick;
    logic              o_bit_tick;

`ifdef BAUD_GEN_FRAC_EN
    modport master (
        output i_enable, i_div, i_div_load, i_frac,
        input  o_div_ack, o_div_active, o_tick, o_bit_tick
    );

    modport slave (
        input  i_enable, i_div, i_div_load, i_frac,
        output o_div_ack, o_div_active, o_tick, o_bit_tick
    );
`else
    modport master (
        output i_enable, i_div, i_div_load,
        input  o_div_ack, o_div_active, o_tick, o_bit_tick
    );

    modport slave (
        input  i_enable, i_div, i_div_load,
        output o_div_ack, o_div_active, o_tick, o_bit_tick
    );
`endif

endinterface : baud_rate_gen_prog_if

// File: rtl/baud_rate_gen_prog_mod_counter.sv
// -----------------------------------------------------------------------------
// mod_counter
// Counter that runs 0..last and wraps back to 0, with a runtime terminal value.
//   clk    : clock, rising edge
//   reset  : synchronous active-high reset
//   clear  : synchronous clear to 0 (lower priority than reset)
//   enable : advance by one when high
//   last   : terminal count (modulus - 1)
//   wrap   : high in the cycle the counter sits at 'last' while enabled
// -----------------------------------------------------------------------------
module mod_counter #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             enable,
    input  logic [WIDTH-1:0] last,
    output logic             wrap
);

    logic [WIDTH-1:0] count;

    assign wrap = enable && (count == last);

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            count <= '0;
        end else if (enable) begin
            count <= wrap ? '0 : count + WIDTH'(1);
        end
    end

endmodule : mod_counter

// File: rtl/baud_rate_gen_prog.sv
// -----------------------------------------------------------------------------
// baud_rate_gen_prog
// Runtime-programmable baud tick generator for the UART TX/RX path.
//   i_clk   : clock, rising edge
//   i_reset : synchronous active-high reset
//   bus     : baud_rate_gen_prog_if.slave (enable, divisor load/ack, ticks)
// The period counter produces one o_tick every o_div_active cycles; the
// oversample counter marks every OVERSAMPLE-th tick with o_bit_tick.
// A loaded divisor waits in a pending register and takes effect only at a
// period boundary (or immediately while disabled), so a period is never cut.
// Optional feature macro: BAUD_GEN_FRAC_EN adds a fractional divisor that
// stretches selected periods by one cycle.
// -----------------------------------------------------------------------------
module baud_rate_gen_prog #(
    parameter int NB_DIV      = baud_pkg::NB_DIV,
    parameter int DEFAULT_DIV = baud_pkg::DEFAULT_DIV,
    parameter int OVERSAMPLE  = baud_pkg::OVERSAMPLE,
`ifdef BAUD_GEN_FRAC_EN
    parameter int NB_OS       = baud_pkg::NB_OS,
    parameter int NB_FRAC     = baud_pkg::NB_FRAC
`else
    parameter int NB_OS       = baud_pkg::NB_OS
`endif
) (
    input logic                 i_clk,
    input logic                 i_reset,
    baud_rate_gen_prog_if.slave bus
);

    localparam logic [NB_DIV-1:0] DIV_RESET = NB_DIV'(DEFAULT_DIV);
    localparam logic [NB_DIV-1:0] DIV_MIN   = NB_DIV'(baud_pkg::MIN_DIV);
    localparam logic [NB_OS-1:0]  OS_LAST   = NB_OS'(OVERSAMPLE - 1);

    logic [NB_DIV-1:0] div_cur;
    logic [NB_DIV-1:0] div_pend;
    logic              pend_valid;
    logic              apply_q;
    logic [NB_DIV-1:0] load_val;
    logic [NB_DIV-1:0] apply_val;
    logic [NB_DIV-1:0] period_last;
    logic              period_wrap;
    logic              os_wrap;
    logic              apply_edge;
    logic              do_apply;
    logic              extend;

    // Divisors below the minimum would give a degenerate counter, so they
    // are clamped on capture.
    always_comb begin
        load_val = bus.i_div;
        if (bus.i_div < DIV_MIN) begin
            load_val = DIV_MIN;
        end
    end

    // A divisor may change only where the period counter is at 0 anyway:
    // at a wrap, or on any edge while disabled. A load arriving on that
    // same edge is applied directly instead of going through pending.
    always_comb begin
        apply_edge = period_wrap || !bus.i_enable;
        do_apply   = apply_edge && (pend_valid || bus.i_div_load);
        apply_val  = bus.i_div_load ? load_val : div_pend;
    end

    // Terminal count of the period counter; a fractional carry adds one.
    assign period_last = div_cur - NB_DIV'(1) + {{(NB_DIV-1){1'b0}}, extend};

    mod_counter #(
        .WIDTH (NB_DIV)
    ) u_period_cnt (
        .clk    (i_clk),
        .reset  (i_reset),
        .clear  (!bus.i_enable),
        .enable (bus.i_enable),
        .last   (period_last),
        .wrap   (period_wrap)
    );

    mod_counter #(
        .WIDTH (NB_OS)
    ) u_os_cnt (
        .clk    (i_clk),
        .reset  (i_reset),
        .clear  (!bus.i_enable),
        .enable (period_wrap),
        .last   (OS_LAST),
        .wrap   (os_wrap)
    );

    // Divisor bookkeeping and registered outputs. div_cur steers the counter
    // from the application edge onward; the visible o_div_active and the ack
    // pulse follow one cycle later so they always appear together.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            div_cur          <= DIV_RESET;
            div_pend         <= DIV_RESET;
            pend_valid       <= 1'b0;
            apply_q          <= 1'b0;
            bus.o_div_active <= DIV_RESET;
            bus.o_div_ack    <= 1'b0;
            bus.o_tick       <= 1'b0;
            bus.o_bit_tick   <= 1'b0;
        end else begin
            apply_q          <= do_apply;
            bus.o_div_ack    <= apply_q;
            bus.o_div_active <= div_cur;
            bus.o_tick       <= period_wrap;
            bus.o_bit_tick   <= os_wrap;
            if (do_apply) begin
                div_cur    <= apply_val;
                pend_valid <= 1'b0;
            end else if (bus.i_div_load) begin
                div_pend   <= load_val;
                pend_valid <= 1'b1;
            end
        end
    end

`ifdef BAUD_GEN_FRAC_EN
    logic [NB_FRAC-1:0] frac_cur;
    logic [NB_FRAC-1:0] frac_pend;
    logic [NB_FRAC-1:0] frac_acc;
    logic [NB_FRAC:0]   frac_sum;

    assign frac_sum = {1'b0, frac_acc} + {1'b0, frac_cur};

    // The fraction travels with the divisor through the same pending path.
    // Each wrap accumulates it; a carry stretches the following period.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            frac_cur  <= '0;
            frac_pend <= '0;
            frac_acc  <= '0;
            extend    <= 1'b0;
        end else begin
            if (do_apply) begin
                frac_cur <= bus.i_div_load ? bus.i_frac : frac_pend;
            end else if (bus.i_div_load) begin
                frac_pend <= bus.i_frac;
            end
            if (!bus.i_enable) begin
                frac_acc <= '0;
                extend   <= 1'b0;
            end else if (period_wrap) begin
                frac_acc <= frac_sum[NB_FRAC-1:0];
                extend   <= frac_sum[NB_FRAC];
            end
        end
    end
`else
    assign extend = 1'b0;
`endif

endmodule : baud_rate_gen_prog

// File: tb/tb_baud_rate_gen_prog.sv
// -----------------------------------------------------------------------------
// tb_baud_rate_gen_prog
// Self-checking bench for baud_rate_gen_prog: reset state, default cadence,
// runtime load at a period boundary, clamping, back-to-back loads, enable
// gating, reset with a load pending and (with BAUD_GEN_FRAC_EN) the
// fractional divisor.
// Cycle n is the interval after the n-th rising edge following reset release;
// outputs are sampled 1 time unit after each rising edge.
// -----------------------------------------------------------------------------
module tb_baud_rate_gen_prog;
    import baud_pkg::*;

    logic i_clk = 1'b0;
    logic i_reset;

    baud_rate_gen_prog_if bus ();

    baud_rate_gen_prog dut (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .bus     (bus)
    );

    always #5 i_clk = ~i_clk;

    typedef struct {
        logic        en;
        logic        load;
        logic [15:0] div;
        logic        exp_tick;
        logic        exp_ack;
        int          exp_active;
    } vec_t;

    vec_t vecs [11];

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;

    task automatic step();
        @(posedge i_clk);
        #1;
        cyc++;
    endtask

    task automatic checkOutput(input string name, input int actual, input int expected);
        n_checks++;
        if (actual == expected) begin
            n_pass++;
        end else begin
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic en, input logic load, input logic [15:0] div);
        bus.i_enable   = en;
        bus.i_div_load = load;
        bus.i_div      = div;
    endtask

    task automatic do_reset();
        i_reset = 1'b1;
        applyStimulus(1'b0, 1'b0, 16'd0);
        step();
        step();
        i_reset = 1'b0;
        cyc     = 0;
    endtask

    initial begin
        int first_tick;
        int first_bit;
        int ticks;
        int bits;
        int acks;
        int err;
        int ack_cyc;
        int act163;
        int act164;
        int r;
        int s;

        vecs[0]  = '{1'b0, 1'b1, 16'd0,  1'b0, 1'b0, 163};
        vecs[1]  = '{1'b0, 1'b1, 16'd1,  1'b0, 1'b1, 2};
        vecs[2]  = '{1'b1, 1'b0, 16'd0,  1'b0, 1'b1, 2};
        vecs[3]  = '{1'b1, 1'b0, 16'd0,  1'b1, 1'b0, 2};
        vecs[4]  = '{1'b1, 1'b0, 16'd0,  1'b0, 1'b0, 2};
        vecs[5]  = '{1'b1, 1'b0, 16'd0,  1'b1, 1'b0, 2};
        vecs[6]  = '{1'b1, 1'b1, 16'd20, 1'b0, 1'b0, 2};
        vecs[7]  = '{1'b1, 1'b1, 16'd30, 1'b1, 1'b0, 2};
        vecs[8]  = '{1'b1, 1'b0, 16'd0,  1'b0, 1'b1, 30};
        vecs[9]  = '{1'b1, 1'b0, 16'd0,  1'b0, 1'b0, 30};
        vecs[10] = '{1'b0, 1'b0, 16'd0,  1'b0, 1'b0, 30};

`ifdef BAUD_GEN_FRAC_EN
        bus.i_frac = '0;
`endif

        // Reset state, then default cadence with no load.
        do_reset();
        checkOutput("reset_tick", bus.o_tick, 0);
        checkOutput("reset_bit_tick", bus.o_bit_tick, 0);
        checkOutput("reset_ack", bus.o_div_ack, 0);
        checkOutput("reset_div_active", bus.o_div_active, DEFAULT_DIV);
        applyStimulus(1'b1, 1'b0, 16'd0);
        first_tick = -1; first_bit = -1; ticks = 0; bits = 0; acks = 0; err = 0;
        repeat (2 * OVERSAMPLE * DEFAULT_DIV) begin
            step();
            if (bus.o_tick !== logic'(cyc % DEFAULT_DIV == 0)) err++;
            if (bus.o_bit_tick !== logic'(cyc % (DEFAULT_DIV * OVERSAMPLE) == 0)) err++;
            if (bus.o_tick === 1'b1) begin
                ticks++;
                if (first_tick < 0) first_tick = cyc;
            end
            if (bus.o_bit_tick === 1'b1) begin
                bits++;
                if (first_bit < 0) first_bit = cyc;
            end
            if (bus.o_div_ack === 1'b1) acks++;
        end
        checkOutput("dflt_first_tick", first_tick, 163);
        checkOutput("dflt_first_bit_tick", first_bit, 2608);
        checkOutput("dflt_tick_count", ticks, 32);
        checkOutput("dflt_bit_count", bits, 2);
        checkOutput("dflt_pattern_errors", err, 0);
        checkOutput("dflt_div_active", bus.o_div_active, 163);
        checkOutput("dflt_ack_count", acks, 0);

        // Load 10 at cycle 50: the current 163 period completes first.
        do_reset();
        applyStimulus(1'b1, 1'b0, 16'd0);
        ticks = 0; acks = 0; err = 0; ack_cyc = -1; act163 = -1; act164 = -1;
        while (cyc < 200) begin
            step();
            if (bus.o_tick !== logic'(cyc == 163 || (cyc > 163 && (cyc - 163) % 10 == 0))) err++;
            if (bus.o_tick === 1'b1) ticks++;
            if (bus.o_div_ack === 1'b1) begin
                acks++;
                ack_cyc = cyc;
            end
            if (cyc == 163) act163 = int'(bus.o_div_active);
            if (cyc == 164) act164 = int'(bus.o_div_active);
            if (cyc == 50) applyStimulus(1'b1, 1'b1, 16'd10);
            else           applyStimulus(1'b1, 1'b0, 16'd0);
        end
        checkOutput("load_ack_count", acks, 1);
        checkOutput("load_ack_cycle", ack_cyc, 164);
        checkOutput("load_active_at_163", act163, 163);
        checkOutput("load_active_at_164", act164, 10);
        checkOutput("load_tick_errors", err, 0);
        checkOutput("load_tick_count", ticks, 4);

        // Clamping, loads while disabled, back-to-back loads into a wrap.
        do_reset();
        for (int i = 0; i < 11; i++) begin
            applyStimulus(vecs[i].en, vecs[i].load, vecs[i].div);
            step();
            checkOutput($sformatf("vec%0d_tick", i), bus.o_tick, vecs[i].exp_tick);
            checkOutput($sformatf("vec%0d_ack", i), bus.o_div_ack, vecs[i].exp_ack);
            checkOutput($sformatf("vec%0d_div_active", i), bus.o_div_active, vecs[i].exp_active);
        end

        // Enable low mid-period restarts phase and oversample count.
        do_reset();
        applyStimulus(1'b0, 1'b1, 16'd10);
        step();
        applyStimulus(1'b0, 1'b0, 16'd0);
        step();
        step();
        applyStimulus(1'b1, 1'b0, 16'd0);
        r = cyc; ticks = 0;
        repeat (15) begin
            step();
            if (bus.o_tick === 1'b1) ticks++;
        end
        checkOutput("en_ticks_before_gap", ticks, 1);
        applyStimulus(1'b0, 1'b0, 16'd0);
        ticks = 0;
        repeat (5) begin
            step();
            if (bus.o_tick === 1'b1 || bus.o_bit_tick === 1'b1) ticks++;
        end
        checkOutput("en_ticks_while_low", ticks, 0);
        applyStimulus(1'b1, 1'b0, 16'd0);
        s = cyc; ticks = 0; err = 0; first_tick = -1; first_bit = -1; bits = 0;
        repeat (170) begin
            step();
            if (bus.o_tick !== logic'((cyc - s) % 10 == 0)) err++;
            if (bus.o_tick === 1'b1) begin
                ticks++;
                if (first_tick < 0) first_tick = cyc - s;
            end
            if (bus.o_bit_tick === 1'b1) begin
                bits++;
                if (first_bit < 0) first_bit = cyc - s;
            end
        end
        checkOutput("reen_first_tick", first_tick, 10);
        checkOutput("reen_first_bit_tick", first_bit, 160);
        checkOutput("reen_bit_count", bits, 1);
        checkOutput("reen_tick_count", ticks, 17);
        checkOutput("reen_tick_errors", err, 0);

        // Reset on a wrap edge with a load pending discards the load.
        do_reset();
        applyStimulus(1'b1, 1'b0, 16'd0);
        acks = 0;
        while (cyc < 325) begin
            step();
            if (bus.o_div_ack === 1'b1) acks++;
            if (cyc == 165) applyStimulus(1'b1, 1'b1, 16'd10);
            else            applyStimulus(1'b1, 1'b0, 16'd0);
        end
        checkOutput("rst_pending_not_applied", bus.o_div_active, 163);
        i_reset = 1'b1;
        step();
        checkOutput("rst_tick", bus.o_tick, 0);
        checkOutput("rst_bit_tick", bus.o_bit_tick, 0);
        checkOutput("rst_ack", bus.o_div_ack, 0);
        checkOutput("rst_div_active", bus.o_div_active, 163);
        i_reset = 1'b0;
        cyc = 0; first_tick = -1;
        repeat (400) begin
            step();
            if (bus.o_div_ack === 1'b1) acks++;
            if (bus.o_tick === 1'b1 && first_tick < 0) first_tick = cyc;
        end
        checkOutput("rst_ack_count", acks, 0);
        checkOutput("rst_first_tick", first_tick, 163);
        checkOutput("rst_final_div_active", bus.o_div_active, 163);

`ifdef BAUD_GEN_FRAC_EN
        // Fraction 8/16 on divisor 10: periods alternate 10 and 11.
        begin
            int times [$];
            int prev_p;
            int p;
            do_reset();
            bus.i_frac = 4'd8;
            applyStimulus(1'b0, 1'b1, 16'd10);
            step();
            bus.i_frac = 4'd0;
            applyStimulus(1'b0, 1'b0, 16'd0);
            step();
            applyStimulus(1'b1, 1'b0, 16'd0);
            repeat (400) begin
                step();
                if (bus.o_tick === 1'b1) times.push_back(cyc);
            end
            checkOutput("frac_tick_count_ok", int'(times.size() >= 33), 1);
            if (times.size() >= 33) begin
                err = 0;
                prev_p = times[1] - times[0];
                for (int k = 2; k < 33; k++) begin
                    p = times[k] - times[k-1];
                    if ((p != 10 && p != 11) || p == prev_p) err++;
                    prev_p = p;
                end
                checkOutput("frac_span_32_ticks", times[32] - times[0], 336);
                checkOutput("frac_alternation_errors", err, 0);
            end
        end
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule : tb_baud_rate_gen_prog

// File: doc/baud_rate_gen_prog.md
Name: baud_rate_gen_prog

Overview:
Runtime-programmable baud tick generator for the UART TX/RX path. It replaces the fixed-modulus generator.
- Produces an oversample tick (o_tick) and a bit-rate tick (o_bit_tick, every OVERSAMPLE-th o_tick).
- Divisor is loadable at runtime via a load/ack handshake, plus an enable that restarts phase.
- Sits between the clock domain's config register block and uart_rx/uart_tx.

Parameters:
NB_DIV, 16, width of divisor and period counter.
DEFAULT_DIV, 163, divisor active after reset (50 MHz, 19200 baud, x16).
OVERSAMPLE, 16, o_tick periods per o_bit_tick.
NB_OS, 4, width of oversample counter (clog2(OVERSAMPLE)).
NB_FRAC, 4, fractional divisor width (used only with the optional feature).

Ports:
i_clk  in  1  clock; all logic on rising edge.
i_reset  in  1  synchronous, active-high reset.
i_enable  in  1  run when high; low clears counters, suppresses ticks.
i_div  in  NB_DIV  new divisor value.
i_div_load  in  1  one-cycle strobe; captures i_div.
o_div_ack  out  1  one-cycle pulse when the loaded divisor becomes active.
o_div_active  out  NB_DIV  currently applied divisor.
o_tick  out  1  registered oversample tick, one cycle wide.
o_bit_tick  out  1  registered bit tick, one cycle wide, coincident with an o_tick.

Behaviour:
- Reset (sync, highest priority, any state):
  - period counter = 0, os counter = 0, pending flag = 0.
  - o_div_active = DEFAULT_DIV; o_tick = o_bit_tick = o_div_ack = 0.
  - Any load in flight is discarded.
- Period counter:
  - While i_enable, counts 0..o_div_active-1.
  - wrap = (counter == o_div_active-1); at wrap the counter goes to 0.
  - o_tick is registered high the cycle after wrap. Period is exactly o_div_active cycles.
  - Enable high from cycle 0 after reset gives the first o_tick at cycle DEFAULT_DIV.
- Oversample counter: increments on each wrap, modulo OVERSAMPLE. o_bit_tick is high with the o_tick whose wrap takes the os counter from OVERSAMPLE-1 to 0.
- Enable low:
  - Both counters are forced to 0 and the fractional accumulator is cleared.
  - o_tick and o_bit_tick stay 0.
  - Re-enable restarts a full period: first o_tick o_div_active cycles later.
- Divisor load:
  - i_div_load captures i_div into the pending register. Values < 2 are clamped to 2.
  - Pending is applied at the next wrap, or on the next edge if i_enable is low.
  - Load in the same cycle as a wrap: applied at that wrap, so the next period uses the new value.
  - o_div_ack pulses the cycle after application, together with the updated o_div_active.
  - Second load before application: the latest value overwrites, and only one ack is issued.
- Divisor application never truncates the current period.

Optional Feature:
Macro BAUD_GEN_FRAC_EN.
- Defined:
  - Adds input i_frac [NB_FRAC], latched with i_div on load.
  - At each wrap, a NB_FRAC-bit accumulator adds the active fraction.
  - On carry-out, the following period is o_div_active+1 cycles.
  - Mean period = div + frac/2^NB_FRAC.
- Undefined: port and accumulator are absent; period is exactly o_div_active.

Decomposition:
- Package baud_pkg:
  - NB_DIV, NB_OS, NB_FRAC, OVERSAMPLE defaults.
  - MIN_DIV = 2, DEFAULT_DIV.
- Sub-module mod_counter: parameterised width, runtime modulus, enable, sync clear, wrap output.
- mod_counter is instantiated for both the period and oversample counters.

Test Plan:
- Reset, enable held high, no load -> o_tick at cycles 163, 326, 489…; o_bit_tick first at cycle 2608 and every 2608 cycles after; o_div_active = 163.
- Load i_div = 10 at cycle 50 of a 163 period -> current period ends at 163; o_div_ack at cycle 164 with o_div_active = 10; subsequent o_tick spacing is 10.
- i_enable low for 5 cycles mid-period, then high -> no ticks while low; next o_tick exactly o_div_active cycles after re-enable; os count restarts, so o_bit_tick comes 16 ticks later.
- Load i_div = 0 and then i_div = 1 -> o_div_active = 2; o_tick every 2 cycles. Two loads before a wrap (20 then 30) -> single ack, o_div_active = 30.
- Assert i_reset mid-period with a load pending -> next cycle all outputs 0, o_div_active = 163, no ack ever issued for the discarded load.
- With BAUD_GEN_FRAC_EN: i_div = 10, i_frac = 8 -> o_tick periods alternate 10, 11; mean 10.5 over 32 ticks.
